// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that pulls bytes from an upstream FIFO with a one-cycle read strobe.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit between data bit 7 and the stop bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] din,
    output logic       re,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DONE_AT = CW'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY = 3'd5,
`endif
        STOP   = 3'd6
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shreg;

    // All outputs are registered; tx is loaded with the value of the bit about to start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tx    <= 1'b1;
            re    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            re   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!empty) begin
                        state <= READ;
                        re    <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                READ: begin
                    state <= LOAD;
                end

                // din is valid here, one cycle after the FIFO saw re.
                LOAD: begin
                    shreg <= din;
                    cnt   <= '0;
                    tx    <= 1'b0;
                    state <= START;
                end

                START: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        idx   <= 3'd0;
                        tx    <= shreg[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            tx    <= ^shreg;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                            tx  <= shreg[idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                // done is set one edge early so it lands in the final stop-bit cycle.
                STOP: begin
                    tx <= 1'b1;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        done <= (cnt == DONE_AT);
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with a small upstream FIFO model.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       empty;
    logic [7:0] din = 8'h00;
    logic       re;
    logic       tx;
    logic       busy;
    logic       done;

    logic       hold_empty = 1'b0;
    logic [7:0] mem [0:15];
    int         wr_count  = 0;
    int         rd_count  = 0;
    int         re_pulses = 0;
    int         checks    = 0;
    int         failures  = 0;

    assign empty = hold_empty || (rd_count == wr_count);

    always #5 clk = ~clk;

    // Upstream FIFO: read data appears the cycle after re is sampled.
    always @(posedge clk) begin
        if (re) begin
            din       <= mem[rd_count[3:0]];
            rd_count  <= rd_count + 1;
            re_pulses <= re_pulses + 1;
        end
    end

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .empty (empty),
        .din   (din),
        .re    (re),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushByte(input logic [7:0] b);
        mem[wr_count[3:0]] = b;
        wr_count++;
    endtask

    task automatic waitRe(output int waited);
        waited = 0;
        while (re !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Checks {re,busy,done,tx} on every cycle from the read strobe to the first idle cycle.
    task automatic captureFrame(input logic [7:0] b, input int exp_wait);
        int          waited;
        logic [10:0] bits;
        logic [3:0]  exp;
        waitRe(waited);
        checkOutput($sformatf("re_wait_%02h", b), waited, exp_wait);
        if (re !== 1'b1) return;
        bits    = 11'h7ff;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        if (PAR) bits[9] = ^b;
        checkOutput($sformatf("read_cycle_%02h", b), {re, busy, done, tx}, 4'b1101);
        @(negedge clk);
        checkOutput($sformatf("load_cycle_%02h", b), {re, busy, done, tx}, 4'b0101);
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                exp = {1'b0, 1'b1, (k == NBITS - 1) && (c == CPB - 1), bits[k]};
                checkOutput($sformatf("byte%02h_bit%0d_c%0d", b, k, c), {re, busy, done, tx}, exp);
            end
        end
        @(negedge clk);
        checkOutput($sformatf("after_stop_%02h", b), {re, busy, done, tx}, 4'b0001);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lows;
        int highs;
        int w;
        int p0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", {re, busy, done, tx}, 4'b0001);
        rst = 1'b1;

        lows  = 0;
        highs = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (re !== 1'b0 || busy !== 1'b0) highs++;
        end
        checkOutput("idle_tx_low", lows, 0);
        checkOutput("idle_re_busy", highs, 0);

        pushByte(8'hA5);
        captureFrame(8'hA5, 1);
        pushByte(8'h07);
        captureFrame(8'h07, 1);

        p0 = re_pulses;
        pushByte(8'h55);
        pushByte(8'h0F);
        captureFrame(8'h55, 1);
        captureFrame(8'h0F, 1);
        checkOutput("b2b_re_pulses", re_pulses - p0, 2);

        p0 = re_pulses;
        pushByte(8'h3C);
        pushByte(8'h81);
        fork
            begin
                repeat (10) @(negedge clk);
                hold_empty = 1'b1;
            end
        join_none
        captureFrame(8'h3C, 1);
        highs = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) highs++;
        end
        checkOutput("held_idle", highs, 0);
        checkOutput("held_no_read", re_pulses - p0, 1);
        hold_empty = 1'b0;
        captureFrame(8'h81, 1);

        p0 = re_pulses;
        pushByte(8'h00);
        waitRe(w);
        checkOutput("rst_re_wait", w, 1);
        repeat (10) @(negedge clk);
        checkOutput("pre_reset_tx", {busy, tx}, 2'b10);
        #2 rst = 1'b0;
        #1 checkOutput("async_reset", {re, busy, done, tx}, 4'b0001);
        @(negedge clk);
        rst = 1'b1;
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        checkOutput("post_reset_quiet", lows, 0);
        checkOutput("post_reset_reads", re_pulses - p0, 1);

        pushByte(8'hC3);
        captureFrame(8'hC3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
